// File: rtl/rv32i_types.sv
//============================================================================
// Module : rv32i_types
// Desc   : Shared ROB entry, dispatch and writeback bus types.
// Rev    : 1.0
//============================================================================
`default_nettype none

package rv32i_types;

    localparam int C_XLEN  = 32;
    localparam int C_REG_W = 5;

    typedef struct packed {
        logic               valid;
        logic               done;
        logic [C_REG_W-1:0] rd_addr;
        logic [C_XLEN-1:0]  data;
        logic [C_XLEN-1:0]  pc;
        logic               mispredict;
        logic [C_XLEN-1:0]  target;
    } rob_entry_t;

    typedef struct packed {
        logic [C_REG_W-1:0] rd_addr;
        logic [C_XLEN-1:0]  pc;
    } disp_payload_t;

    typedef struct packed {
        logic [C_XLEN-1:0]  data;
        logic               mispredict;
        logic [C_XLEN-1:0]  target;
    } cdb_payload_t;

endpackage

`default_nettype wire

// File: rtl/rob_commit_sel.sv
//============================================================================
// Module : rob_commit_sel
// Desc   : Picks the retirable prefix from head; stops after a mispredict.
// Rev    : 1.0
//============================================================================
`default_nettype none

module rob_commit_sel #(
    parameter int COMMIT_W = 2,
    parameter int CNT_W    = $clog2(COMMIT_W + 1)
) (
    input  logic [COMMIT_W-1:0] done_vec,
    input  logic [COMMIT_W-1:0] mp_vec,
    output logic [CNT_W-1:0]    retire_cnt,
    output logic                mp_stop
);

    logic w_blocked;

    always_comb begin
        retire_cnt = '0;
        mp_stop    = 1'b0;
        w_blocked  = 1'b0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (!w_blocked && done_vec[k]) begin
                retire_cnt = retire_cnt + CNT_W'(1);
                // A mispredicted branch closes the retire group.
                if (mp_vec[k]) begin
                    mp_stop   = 1'b1;
                    w_blocked = 1'b1;
                end
            end else begin
                w_blocked = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rob_wide.sv
//============================================================================
// Module : rob_wide
// Desc   : Multi-slot dispatch / writeback / in-order commit reorder buffer.
// Rev    : 1.0
//============================================================================
`default_nettype none

module rob_wide
    import rv32i_types::*;
#(
    parameter int DEPTH_BITS = 5,
    parameter int DISPATCH_W = 2,
    parameter int COMMIT_W   = 2,
    parameter int CDB_PORTS  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DISPATCH_W-1:0]                disp_valid,
    input  logic [DISPATCH_W-1:0][4:0]           disp_rd_addr,
    input  logic [DISPATCH_W-1:0][31:0]          disp_pc,
    output logic                                 disp_ready,
    output logic [DISPATCH_W-1:0][DEPTH_BITS-1:0] disp_rob_id,
    input  logic [CDB_PORTS-1:0]                 cdb_valid,
    input  logic [CDB_PORTS-1:0][DEPTH_BITS-1:0] cdb_rob_id,
    input  logic [CDB_PORTS-1:0][31:0]           cdb_data,
    input  logic [CDB_PORTS-1:0]                 cdb_mispredict,
    input  logic [CDB_PORTS-1:0][31:0]           cdb_target,
    output logic [COMMIT_W-1:0]                  commit_valid,
    output logic [COMMIT_W-1:0][4:0]             commit_rd_addr,
    output logic [COMMIT_W-1:0][31:0]            commit_rd_data,
    output logic [COMMIT_W-1:0][DEPTH_BITS-1:0]  commit_rob_id,
    output logic [COMMIT_W-1:0][63:0]            commit_order,
    output logic                                 flush,
    output logic [31:0]                          flush_pc,
    output logic [DEPTH_BITS:0]                  count
);

    localparam int C_DEPTH = 2 ** DEPTH_BITS;
    localparam int C_DN_W  = $clog2(DISPATCH_W + 1);
    localparam int C_CN_W  = $clog2(COMMIT_W + 1);

    rob_entry_t                  r_rob [C_DEPTH];
    logic [DEPTH_BITS-1:0]       r_head;
    logic [DEPTH_BITS-1:0]       r_tail;
    logic [DEPTH_BITS:0]         r_count;
    logic [63:0]                 r_order;

    logic [DEPTH_BITS:0]         w_free;
    logic [C_DN_W-1:0]           w_disp_n;
    logic                        w_disp_fire;
    disp_payload_t               w_disp [DISPATCH_W];
    cdb_payload_t                w_cdb  [CDB_PORTS];
    logic [COMMIT_W-1:0][DEPTH_BITS-1:0] w_cand_id;
    logic [COMMIT_W-1:0]         w_done_vec;
    logic [COMMIT_W-1:0]         w_mp_vec;
    logic [COMMIT_W-1:0]         w_retire_mask;
    logic [C_CN_W-1:0]           w_retire_n;
    logic                        w_flush_gen;
    logic [31:0]                 w_flush_target;

    assign count      = r_count;
    assign w_free     = (DEPTH_BITS+1)'(C_DEPTH) - r_count;
    assign disp_ready = (w_free >= (DEPTH_BITS+1)'(DISPATCH_W));
    // Nothing is accepted while the buffer is being cleared by a redirect.
    assign w_disp_fire = disp_ready && !w_flush_gen;

    generate
        for (genvar k = 0; k < DISPATCH_W; k++) begin : g_disp
            assign disp_rob_id[k] = r_tail + DEPTH_BITS'(k);
            assign w_disp[k]      = '{rd_addr: disp_rd_addr[k], pc: disp_pc[k]};
        end
        for (genvar p = 0; p < CDB_PORTS; p++) begin : g_cdb
            assign w_cdb[p] = '{data: cdb_data[p], mispredict: cdb_mispredict[p],
                                target: cdb_target[p]};
        end
        for (genvar k = 0; k < COMMIT_W; k++) begin : g_cand
            assign w_cand_id[k]     = r_head + DEPTH_BITS'(k);
            assign w_done_vec[k]    = r_rob[w_cand_id[k]].valid & r_rob[w_cand_id[k]].done;
            assign w_mp_vec[k]      = r_rob[w_cand_id[k]].mispredict;
            assign w_retire_mask[k] = (C_CN_W'(k) < w_retire_n);
        end
    endgenerate

    always_comb begin
        w_disp_n = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            w_disp_n = w_disp_n + C_DN_W'(disp_valid[k]);
        end
    end

    always_comb begin
        w_flush_target = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (w_retire_mask[k] && w_mp_vec[k]) begin
                w_flush_target = r_rob[w_cand_id[k]].target;
            end
        end
    end

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W),
        .CNT_W    (C_CN_W)
    ) u_commit_sel (
        .done_vec   (w_done_vec),
        .mp_vec     (w_mp_vec),
        .retire_cnt (w_retire_n),
        .mp_stop    (w_flush_gen)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_order      <= '0;
            commit_valid <= '0;
            flush        <= 1'b0;
            flush_pc     <= '0;
            for (int i = 0; i < C_DEPTH; i++) begin
                r_rob[i].valid <= 1'b0;
                r_rob[i].done  <= 1'b0;
            end
        end else begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (cdb_valid[p] && r_rob[cdb_rob_id[p]].valid) begin
                    r_rob[cdb_rob_id[p]].done       <= 1'b1;
                    r_rob[cdb_rob_id[p]].data       <= w_cdb[p].data;
                    r_rob[cdb_rob_id[p]].mispredict <= w_cdb[p].mispredict;
                    r_rob[cdb_rob_id[p]].target     <= w_cdb[p].target;
                end
            end

            for (int k = 0; k < COMMIT_W; k++) begin
                if (w_retire_mask[k]) begin
                    r_rob[w_cand_id[k]].valid <= 1'b0;
                    r_rob[w_cand_id[k]].done  <= 1'b0;
                end
                commit_valid[k]   <= w_retire_mask[k];
                commit_rd_addr[k] <= r_rob[w_cand_id[k]].rd_addr;
                commit_rd_data[k] <= r_rob[w_cand_id[k]].data;
                commit_rob_id[k]  <= w_cand_id[k];
                commit_order[k]   <= r_order + 64'(k);
            end
            r_order <= r_order + 64'(w_retire_n);

            flush <= w_flush_gen;
            if (w_flush_gen) begin
                flush_pc <= w_flush_target;
                for (int i = 0; i < C_DEPTH; i++) begin
                    r_rob[i].valid <= 1'b0;
                    r_rob[i].done  <= 1'b0;
                end
                r_head  <= r_head + DEPTH_BITS'(w_retire_n);
                r_tail  <= r_head + DEPTH_BITS'(w_retire_n);
                r_count <= '0;
            end else begin
                for (int k = 0; k < DISPATCH_W; k++) begin
                    if (w_disp_fire && disp_valid[k]) begin
                        r_rob[disp_rob_id[k]] <= '{valid: 1'b1, done: 1'b0,
                                                   rd_addr: w_disp[k].rd_addr, data: '0,
                                                   pc: w_disp[k].pc, mispredict: 1'b0,
                                                   target: '0};
                    end
                end
                r_head  <= r_head + DEPTH_BITS'(w_retire_n);
                r_tail  <= r_tail + (w_disp_fire ? DEPTH_BITS'(w_disp_n) : '0);
                r_count <= r_count
                         + (w_disp_fire ? (DEPTH_BITS+1)'(w_disp_n) : '0)
                         - (DEPTH_BITS+1)'(w_retire_n);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rob_wide.sv
//============================================================================
// Module : tb_rob_wide
// Desc   : Directed self-checking bench for rob_wide.
// Rev    : 1.0
//============================================================================
`default_nettype none

module tb_rob_wide;

    localparam int DB = 5;
    localparam int DW = 2;
    localparam int CW = 2;
    localparam int CP = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [DW-1:0]          disp_valid;
    logic [DW-1:0][4:0]     disp_rd_addr;
    logic [DW-1:0][31:0]    disp_pc;
    logic                   disp_ready;
    logic [DW-1:0][DB-1:0]  disp_rob_id;
    logic [CP-1:0]          cdb_valid;
    logic [CP-1:0][DB-1:0]  cdb_rob_id;
    logic [CP-1:0][31:0]    cdb_data;
    logic [CP-1:0]          cdb_mispredict;
    logic [CP-1:0][31:0]    cdb_target;
    logic [CW-1:0]          commit_valid;
    logic [CW-1:0][4:0]     commit_rd_addr;
    logic [CW-1:0][31:0]    commit_rd_data;
    logic [CW-1:0][DB-1:0]  commit_rob_id;
    logic [CW-1:0][63:0]    commit_order;
    logic                   flush;
    logic [31:0]            flush_pc;
    logic [DB:0]            count;

    int n_pass  = 0;
    int n_total = 0;

    rob_wide #(
        .DEPTH_BITS (DB),
        .DISPATCH_W (DW),
        .COMMIT_W   (CW),
        .CDB_PORTS  (CP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .disp_valid     (disp_valid),
        .disp_rd_addr   (disp_rd_addr),
        .disp_pc        (disp_pc),
        .disp_ready     (disp_ready),
        .disp_rob_id    (disp_rob_id),
        .cdb_valid      (cdb_valid),
        .cdb_rob_id     (cdb_rob_id),
        .cdb_data       (cdb_data),
        .cdb_mispredict (cdb_mispredict),
        .cdb_target     (cdb_target),
        .commit_valid   (commit_valid),
        .commit_rd_addr (commit_rd_addr),
        .commit_rd_data (commit_rd_data),
        .commit_rob_id  (commit_rob_id),
        .commit_order   (commit_order),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        disp_valid     = '0;
        disp_rd_addr   = '0;
        disp_pc        = '0;
        cdb_valid      = '0;
        cdb_rob_id     = '0;
        cdb_data       = '0;
        cdb_mispredict = '0;
        cdb_target     = '0;
    endtask

    task automatic tick_clr();
        tick();
        clear_in();
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Two-slot dispatch; rd_addr = id+1 so committed fields are traceable.
    task automatic disp2(input int id0);
        disp_valid = 2'b11;
        for (int k = 0; k < DW; k++) begin
            disp_rd_addr[k] = 5'(id0 + k + 1);
            disp_pc[k]      = 32'(4 * (id0 + k));
        end
        tick();
        disp_valid = '0;
    endtask

    task automatic wb(input int port, input int id, input logic mp, input logic [31:0] tgt);
        cdb_valid[port]      = 1'b1;
        cdb_rob_id[port]     = DB'(id);
        cdb_data[port]       = 32'h100 + 32'(id);
        cdb_mispredict[port] = mp;
        cdb_target[port]     = tgt;
    endtask

    initial begin
        int waited;
        do_reset();
        check("rst_count", count, 0);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_flush", flush, 0);
        check("rst_flush_pc", flush_pc, 0);
        check("rst_ready", disp_ready, 1);
        check("rst_id0", disp_rob_id[0], 0);
        check("rst_id1", disp_rob_id[1], 1);

        // Fill to capacity with no writeback.
        for (int c = 0; c < 16; c++) begin
            check("fill_id0", disp_rob_id[0], 2 * c);
            check("fill_id1", disp_rob_id[1], 2 * c + 1);
            check("fill_count", count, 2 * c);
            check("fill_ready", disp_ready, 1);
            disp2(2 * c);
        end
        check("full_count", count, 32);
        check("full_ready", disp_ready, 0);
        check("full_commit", commit_valid, 0);
        disp_valid = 2'b11;
        tick_clr();
        check("full_drop_count", count, 32);
        check("full_drop_tail", disp_rob_id[0], 0);

        // Reverse-order writeback, in-order commit.
        do_reset();
        disp2(0);
        disp2(2);
        check("rev_count", count, 4);
        wb(0, 3, 1'b0, 0); tick_clr();
        wb(0, 2, 1'b0, 0); tick_clr();
        wb(0, 1, 1'b0, 0); tick_clr();
        check("rev_hold", commit_valid, 0);
        wb(0, 0, 1'b0, 0); tick_clr();
        check("rev_same_cycle", commit_valid, 0);
        tick_clr();
        check("rev_a_valid", commit_valid, 2'b11);
        check("rev_a_id0", commit_rob_id[0], 0);
        check("rev_a_id1", commit_rob_id[1], 1);
        check("rev_a_ord0", commit_order[0], 0);
        check("rev_a_ord1", commit_order[1], 1);
        check("rev_a_data0", commit_rd_data[0], 32'h100);
        check("rev_a_data1", commit_rd_data[1], 32'h101);
        check("rev_a_rd1", commit_rd_addr[1], 2);
        check("rev_a_count", count, 2);
        tick_clr();
        check("rev_b_valid", commit_valid, 2'b11);
        check("rev_b_id0", commit_rob_id[0], 2);
        check("rev_b_id1", commit_rob_id[1], 3);
        check("rev_b_ord0", commit_order[0], 2);
        check("rev_b_ord1", commit_order[1], 3);
        check("rev_b_count", count, 0);
        tick_clr();
        check("rev_idle", commit_valid, 0);

        // Hole at ID 4 blocks ID 5.
        do_reset();
        disp2(0);
        disp2(2);
        disp2(4);
        wb(0, 0, 1'b0, 0); wb(1, 1, 1'b0, 0); wb(2, 2, 1'b0, 0); wb(3, 3, 1'b0, 0);
        tick_clr();
        wb(0, 5, 1'b0, 0);
        tick_clr();
        check("hole_c01", commit_valid, 2'b11);
        tick_clr();
        check("hole_c23", commit_valid, 2'b11);
        check("hole_c23_id0", commit_rob_id[0], 2);
        tick_clr();
        check("hole_wait", commit_valid, 0);
        wb(0, 4, 1'b0, 0);
        tick_clr();
        check("hole_wait2", commit_valid, 0);
        tick_clr();
        check("hole_c45", commit_valid, 2'b11);
        check("hole_id0", commit_rob_id[0], 4);
        check("hole_id1", commit_rob_id[1], 5);
        check("hole_ord0", commit_order[0], 4);
        check("hole_ord1", commit_order[1], 5);

        // Mispredict at ID 2 flushes 3..7; dispatch in that cycle is dropped.
        do_reset();
        disp2(0);
        disp2(2);
        disp2(4);
        disp2(6);
        wb(0, 0, 1'b0, 0); wb(1, 1, 1'b0, 0); wb(2, 2, 1'b1, 32'h1000); wb(3, 3, 1'b0, 0);
        tick_clr();
        wb(0, 4, 1'b0, 0); wb(1, 5, 1'b0, 0); wb(2, 6, 1'b0, 0);
        tick_clr();
        check("mp_c01", commit_valid, 2'b11);
        check("mp_c01_count", count, 6);
        check("mp_c01_flush", flush, 0);
        disp_valid = 2'b11;
        tick_clr();
        check("mp_valid", commit_valid, 2'b01);
        check("mp_id", commit_rob_id[0], 2);
        check("mp_ord", commit_order[0], 2);
        check("mp_flush", flush, 1);
        check("mp_flush_pc", flush_pc, 32'h1000);
        check("mp_count", count, 0);
        check("mp_tail", disp_rob_id[0], 3);
        for (int c = 0; c < 3; c++) begin
            tick_clr();
            check("mp_after_valid", commit_valid, 0);
            check("mp_after_flush", flush, 0);
        end

        // Full buffer: commit 2 while a dispatch is attempted.
        do_reset();
        for (int c = 0; c < 16; c++) disp2(2 * c);
        wb(0, 0, 1'b0, 0); wb(1, 1, 1'b0, 0);
        tick_clr();
        disp_valid = 2'b11;
        check("fc_ready", disp_ready, 0);
        tick_clr();
        check("fc_valid", commit_valid, 2'b11);
        check("fc_count", count, 30);
        check("fc_tail", disp_rob_id[0], 0);

        // Reset in the middle of traffic.
        wb(0, 2, 1'b0, 0);
        rst = 1'b1;
        tick_clr();
        rst = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", commit_valid, 0);
        tick_clr();
        check("mid_rst_after", commit_valid, 0);
        check("mid_rst_tail", disp_rob_id[0], 0);

        // Head at 31, wrap to ID 0 in the same commit group.
        do_reset();
        for (int c = 0; c < 15; c++) disp2(2 * c);
        disp_valid      = 2'b01;
        disp_rd_addr[0] = 5'd31;
        tick_clr();
        check("wrap_pre_count", count, 31);
        for (int b = 0; b < 31; b += 4) begin
            for (int p = 0; p < CP; p++) begin
                if (b + p < 31) wb(p, b + p, 1'b0, 0);
            end
            tick_clr();
        end
        waited = 0;
        while (count != 0 && waited < 64) begin
            tick();
            waited++;
        end
        check("wrap_drain", count, 0);
        check("wrap_id0", disp_rob_id[0], 31);
        check("wrap_id1", disp_rob_id[1], 0);
        disp2(31);
        check("wrap_count", count, 2);
        check("wrap_tail", disp_rob_id[0], 1);
        wb(0, 31, 1'b0, 0); wb(1, 0, 1'b0, 0);
        tick_clr();
        tick_clr();
        check("wrap_valid", commit_valid, 2'b11);
        check("wrap_cid0", commit_rob_id[0], 31);
        check("wrap_cid1", commit_rob_id[1], 0);
        check("wrap_ord0", commit_order[0], 31);
        check("wrap_ord1", commit_order[1], 32);
        check("wrap_data0", commit_rd_data[0], 32'h11f);
        check("wrap_data1", commit_rd_data[1], 32'h100);
        check("wrap_end_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rob_wide.md
ROB_WIDE -- requirements
Module: rob_wide

Interface
REQ-001 Parameter DEPTH_BITS, 5, log2 of entry count (DEPTH = 2**DEPTH_BITS).
REQ-002 Parameter DISPATCH_W, 2, dispatch slots per cycle.
REQ-003 Parameter COMMIT_W, 2, commit slots per cycle.
REQ-004 Parameter CDB_PORTS, 4, writeback ports.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 disp_valid  input  DISPATCH_W  per-slot dispatch request; must be a contiguous prefix (slot 0 first).
REQ-008 disp_rd_addr  input  DISPATCH_W x 5  destination register per slot.
REQ-009 disp_pc  input  DISPATCH_W x 32  instruction PC per slot.
REQ-010 disp_ready  output  1  high when free entries >= DISPATCH_W.
REQ-011 disp_rob_id  output  DISPATCH_W x DEPTH_BITS  allocated IDs, tail+k, combinational.
REQ-012 cdb_valid  input  CDB_PORTS  writeback valid per port.
REQ-013 cdb_rob_id  input  CDB_PORTS x DEPTH_BITS  target entry.
REQ-014 cdb_data  input  CDB_PORTS x 32  result value.
REQ-015 cdb_mispredict  input  CDB_PORTS  entry is a mispredicted branch.
REQ-016 cdb_target  input  CDB_PORTS x 32  correct next PC when mispredicted.
REQ-017 commit_valid  output  COMMIT_W  registered per-slot retire strobe, contiguous prefix.
REQ-018 commit_rd_addr / commit_rd_data / commit_rob_id  output  COMMIT_W x (5 / 32 / DEPTH_BITS)  retired entry fields.
REQ-019 commit_order  output  COMMIT_W x 64  retirement sequence number.
REQ-020 flush / flush_pc  output  1 / 32  registered one-cycle redirect pulse and target.
REQ-021 count  output  DEPTH_BITS+1  occupied entries, 0..DEPTH.

Function
REQ-022 Dispatch all-or-nothing: when disp_ready, every valid slot k writes entry tail+k (mod DEPTH) with done=0, and tail advances by popcount(disp_valid).
REQ-023 Dispatch with disp_ready low, or in a cycle where flush is being generated, SHALL be dropped with no state change.
REQ-024 A CDB write to a valid entry SHALL set done=1 and latch data, mispredict, target; writes to invalid entries SHALL be ignored.
REQ-025 Commit SHALL retire, in order from head, the longest prefix (<= COMMIT_W) of entries valid and done at cycle start; outputs appear next cycle (1-cycle latency).
REQ-026 A CDB write arriving in the same cycle makes the entry eligible next cycle, not the current one.
REQ-027 A retiring mispredicted entry SHALL be the last slot retired that cycle; next cycle flush=1, flush_pc=its target.
REQ-028 On flush generation, all entries SHALL be invalidated, tail set to new head, count to 0.
REQ-029 count_next = count + dispatched - committed; simultaneous dispatch and commit at DEPTH SHALL stay exact.
REQ-030 head/tail SHALL wrap modulo DEPTH; full when count==DEPTH, empty when count==0.
REQ-031 commit_order starts at 0 and increments by 1 per retired instruction across slots.
REQ-032 Idle cycles: commit_valid=0, flush=0; data outputs don't-care.

Reset
REQ-033 On rst: head=tail=0, count=0, all valid/done=0, order=0, commit_valid=0, flush=0, flush_pc=0.
REQ-034 rst mid-operation SHALL discard all in-flight entries and pending flush within the same edge.

Structure
REQ-035 rob_entry_t (valid, done, rd_addr, data, pc, mispredict, target) and CDB/dispatch bus typedefs SHALL live in rv32i_types.
REQ-036 Commit-prefix selection SHALL be a sub-module rob_commit_sel (done vector in, retire count and mispredict stop out).

Verification
REQ-037 Dispatch 2/cycle for 16 cycles, no writeback -> count=32, disp_ready=0 from cycle 16, IDs 0..31.
REQ-038 Fill 4, writeback IDs 3,2,1,0 -> commits 0,1 then 2,3; commit_order 0..3.
REQ-039 ID 5 done before ID 4 -> nothing retires until ID 4 done, then 4,5 same cycle.
REQ-040 ID 2 mispredict target 0x1000, IDs 3..6 done -> ID 2 retires, flush=1, flush_pc=0x1000 next cycle, count=0, 3..6 never commit.
REQ-041 Full ROB, commit 2 and dispatch attempt same cycle -> dispatch rejected, count=30 next cycle.
REQ-042 Head at 31, tail wrapped to 1 -> commit IDs 31,0 in one cycle, order contiguous.
